// File: rtl/tc11_to_binary.sv
// Thermometer-to-binary decoder for the modulo-11 residue channel.
// Two-stage valid/ready pipeline; malformed (bubbled) codes are flagged and counted.
module tc11_to_binary #(
    parameter int BUBBLE_FIX = 1,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [10:1]      in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4:1]       out,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic [10:1] s1_code;
    logic        s1_bad;
    logic        s1_valid;
    logic        in_fire;
    logic        s1_advance;
    logic        out_fire;
    logic        in_bad;
    logic [3:0]  pop;
    logic [3:0]  out_next;

    assign in_ready   = !s1_valid || !out_valid || out_ready;
    assign in_fire    = in_valid && in_ready;
    assign s1_advance = s1_valid && (!out_valid || out_ready);
    assign out_fire   = out_valid && out_ready;

    // A zero sitting directly below a one anywhere means the code is not contiguous.
    assign in_bad = |(in[10:2] & ~in[9:1]);

    always_comb begin
        pop = 4'd0;
        for (int i = 1; i <= 10; i++) begin
            pop = pop + {3'b000, s1_code[i]};
        end
    end

    assign out_next = (s1_bad && (BUBBLE_FIX == 0)) ? 4'hF : pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_code  <= '0;
            s1_bad   <= 1'b0;
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_code  <= in;
            s1_bad   <= in_bad;
            s1_valid <= 1'b1;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= 4'h0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
        end else if (s1_advance) begin
            out       <= out_next;
            out_err   <= s1_bad;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear takes priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= '0;
        end else if (out_fire && out_err && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tc11_to_binary.sv
// Self-checking bench for tc11_to_binary: vector table, hand-written corner sequences,
// and a randomized valid/ready stream checked against a popcount/contiguity reference model.
module tb_tc11_to_binary;

    logic        clk;
    logic        rst;
    logic [10:1] in_code;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready0;
    logic [4:1]  out_bin;
    logic [4:1]  out0;
    logic        out_err;
    logic        out_err0;
    logic        out_valid;
    logic        out_valid0;
    logic        out_ready;
    logic        clr_err;
    logic [3:0]  err_cnt;
    logic [7:0]  err_cnt0;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [10:1] sb_q[$];
    int          sent;
    int          bad_seen;
    logic        last_fire;

    tc11_to_binary #(.BUBBLE_FIX(1), .ERR_W(4)) dut (
        .clk(clk), .rst(rst), .in(in_code), .in_valid(in_valid), .in_ready(in_ready),
        .out(out_bin), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
        .clr_err(clr_err), .err_cnt(err_cnt)
    );

    tc11_to_binary #(.BUBBLE_FIX(0), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .in(in_code), .in_valid(in_valid), .in_ready(in_ready0),
        .out(out0), .out_err(out_err0), .out_valid(out_valid0), .out_ready(out_ready),
        .clr_err(clr_err), .err_cnt(err_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:1] code;
        logic [3:0]  exp_out;
        logic [3:0]  exp_out0;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    // Reference: a legal code is exactly 2^n - 1 where n is its number of ones.
    function automatic logic modelBad(logic [10:1] code);
        int n;
        n = $countones(code);
        return int'(code) != ((1 << n) - 1);
    endfunction

    function automatic int modelOut(logic [10:1] code, int fix);
        if (modelBad(code) && fix == 0) return 15;
        return $countones(code);
    endfunction

    task automatic checkOutput(string name, int actual, int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(logic [10:1] code, logic valid, logic ready);
        in_code   = code;
        in_valid  = valid;
        out_ready = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sbStep();
        logic [10:1] c;
        @(negedge clk);
        last_fire = in_valid && in_ready;
        if (last_fire) begin
            sb_q.push_back(in_code);
            sent++;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_beat", sb_q.size(), 1);
            end else begin
                c = sb_q.pop_front();
                checkOutput("sb_out", out_bin, modelOut(c, 1));
                checkOutput("sb_err", out_err, modelBad(c));
                checkOutput("sb_out_nofix", out0, modelOut(c, 0));
                if (modelBad(c)) bad_seen++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;
        int guard;
        logic [10:1] cur;

        for (int i = 0; i <= 10; i++) begin
            vecs[i].code     = 10'((1 << i) - 1);
            vecs[i].exp_out  = 4'(i);
            vecs[i].exp_out0 = 4'(i);
            vecs[i].exp_err  = 1'b0;
        end
        vecs[11] = '{10'b0000000101, 4'd2, 4'hF, 1'b1};
        vecs[12] = '{10'b1000000000, 4'd1, 4'hF, 1'b1};
        vecs[13] = '{10'b0111111110, 4'd8, 4'hF, 1'b1};

        rst = 1'b1;
        clr_err = 1'b0;
        applyStimulus('0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out", out_bin, 0);
        checkOutput("reset_out_err", out_err, 0);
        checkOutput("reset_err_cnt", err_cnt, 0);
        rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);

        // Back-to-back sweep through the vector table with out_ready held high.
        exp_cnt = 0;
        for (int j = 0; j <= 15; j++) begin
            if (j < 14) begin
                applyStimulus(vecs[j].code, 1'b1, 1'b1);
                checkOutput("sweep_in_ready", in_ready, 1);
            end else begin
                applyStimulus('0, 1'b0, 1'b1);
            end
            tick();
            if (j >= 2 && vecs[j-2].exp_err) exp_cnt++;
            if (j == 0) begin
                checkOutput("first_latency_valid", out_valid, 0);
            end else if (j <= 14) begin
                checkOutput("sweep_out_valid", out_valid, 1);
                checkOutput("sweep_out", out_bin, vecs[j-1].exp_out);
                checkOutput("sweep_out_nofix", out0, vecs[j-1].exp_out0);
                checkOutput("sweep_out_err", out_err, vecs[j-1].exp_err);
                checkOutput("sweep_err_cnt", err_cnt, exp_cnt);
            end else begin
                checkOutput("sweep_drained", out_valid, 0);
                checkOutput("sweep_err_cnt_final", err_cnt, 3);
                checkOutput("sweep_err_cnt0_final", err_cnt0, 3);
            end
        end

        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("clr_err_cnt", err_cnt, 0);

        // Backpressure: two beats fill the pipe, the third waits on in_ready.
        applyStimulus(10'b0000000001, 1'b1, 1'b0);
        checkOutput("bp_ready_1", in_ready, 1);
        tick();
        applyStimulus(10'b0000000011, 1'b1, 1'b0);
        checkOutput("bp_ready_2", in_ready, 1);
        tick();
        applyStimulus(10'b0000000111, 1'b1, 1'b0);
        checkOutput("bp_ready_3_blocked", in_ready, 0);
        tick();
        checkOutput("bp_hold_valid", out_valid, 1);
        checkOutput("bp_hold_out", out_bin, 1);
        tick();
        checkOutput("bp_hold_out_again", out_bin, 1);
        checkOutput("bp_still_blocked", in_ready, 0);
        applyStimulus(10'b0000000111, 1'b1, 1'b1);
        checkOutput("bp_release_ready", in_ready, 1);
        tick();
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("bp_out_2_valid", out_valid, 1);
        checkOutput("bp_out_2", out_bin, 2);
        tick();
        checkOutput("bp_out_3_valid", out_valid, 1);
        checkOutput("bp_out_3", out_bin, 3);
        tick();
        checkOutput("bp_empty", out_valid, 0);

        // Saturation of the 4-bit counter, then clear racing an increment.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(10'b1000000000, 1'b1, 1'b1);
            tick();
        end
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("sat_err_cnt", err_cnt, 15);
        checkOutput("sat_err_cnt0", err_cnt0, 20);
        applyStimulus(10'b1000000000, 1'b1, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        checkOutput("clr_race_pending_err", out_valid && out_err, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("clr_race_err_cnt", err_cnt, 0);
        checkOutput("clr_race_err_cnt0", err_cnt0, 0);

        // Asynchronous reset with both stages full.
        applyStimulus(10'b0000000101, 1'b1, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("rst_pre_err_cnt", err_cnt, 1);
        applyStimulus(10'b0000001111, 1'b1, 1'b0);
        tick();
        applyStimulus(10'b0000011111, 1'b1, 1'b0);
        tick();
        applyStimulus('0, 1'b0, 1'b0);
        checkOutput("rst_pre_full", in_ready, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_out_valid", out_valid, 0);
        checkOutput("rst_async_out", out_bin, 0);
        checkOutput("rst_async_err_cnt", err_cnt, 0);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_release_in_ready", in_ready, 1);
        applyStimulus(10'b0001111111, 1'b1, 1'b1);
        tick();
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("rst_seven_latency", out_valid, 0);
        tick();
        checkOutput("rst_seven_valid", out_valid, 1);
        checkOutput("rst_seven_out", out_bin, 7);
        tick();
        checkOutput("rst_no_replay", out_valid, 0);

        // Randomized stream against the reference model.
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        sb_q.delete();
        sent = 0;
        bad_seen = 0;
        last_fire = 1'b1;
        cur = '0;
        guard = 0;
        while (sent < 10000 && guard < 40000) begin
            if (last_fire) begin
                if ($urandom_range(0, 9) < 6) cur = 10'((1 << $urandom_range(0, 10)) - 1);
                else cur = 10'($urandom);
            end
            applyStimulus(cur, 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8));
            sbStep();
            guard++;
        end
        checkOutput("rand_beats_sent", sent, 10000);
        applyStimulus('0, 1'b0, 1'b1);
        guard = 0;
        while (sb_q.size() > 0 && guard < 50) begin
            sbStep();
            guard++;
        end
        checkOutput("rand_drain_left", sb_q.size(), 0);
        tick();
        checkOutput("rand_err_cnt", err_cnt, (bad_seen > 15) ? 15 : bad_seen);
        checkOutput("rand_err_cnt0", err_cnt0, (bad_seen > 255) ? 255 : bad_seen);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
